hdmi_period_ctrl: RTL and testbench



---
 rtl/hdmi_pkg.sv | 38 +++
 rtl/hdmi_delay_line.sv | 19 +
 rtl/hdmi_period_ctrl.sv | 122 ++++++++++++
 tb/tb_hdmi_period_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared period, mode and state encodings for the HDMI transmit path
package hdmi_pkg;
  localparam logic [2:0] PERIOD_CTRL      = 3'b000;
  localparam logic [2:0] PERIOD_AUX_DATA  = 3'b001;
  localparam logic [2:0] PERIOD_VIDEO     = 3'b011;
  localparam logic [2:0] PERIOD_AUX_GUARD = 3'b100;
  localparam logic [2:0] PERIOD_AUX_PRE   = 3'b101;
  localparam logic [2:0] PERIOD_VID_GUARD = 3'b110;
  localparam logic [2:0] PERIOD_VID_PRE   = 3'b111;
  localparam logic [1:0] MODE_GUARD = 2'b00;
  localparam logic [1:0] MODE_AUX   = 2'b01;
  localparam logic [1:0] MODE_CTRL  = 2'b10;
  localparam logic [1:0] MODE_VIDEO = 2'b11;
  typedef enum logic [2:0] {CTRL, AUX_PRE, AUX_GL, AUX_DATA, AUX_GT, VID_PRE, VID_GUARD, VIDEO} state_t;
  typedef struct packed {
    logic [2:0] period;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic [1:0] c1;
    logic [1:0] c2;
    logic       guard;
  } chan_t;
  function automatic chan_t chan_of(state_t s, logic dvi);
    chan_t c;
    c = '{PERIOD_CTRL, MODE_CTRL, MODE_CTRL, MODE_CTRL, 2'b00, 2'b00, 1'b0};
    case (s)
      AUX_PRE:        c = '{PERIOD_AUX_PRE, MODE_CTRL, MODE_CTRL, MODE_CTRL, 2'b01, 2'b01, 1'b0};
      AUX_GL, AUX_GT: c = '{PERIOD_AUX_GUARD, MODE_AUX, MODE_GUARD, MODE_GUARD, 2'b00, 2'b00, 1'b0};
      AUX_DATA:       c = '{PERIOD_AUX_DATA, MODE_AUX, MODE_AUX, MODE_AUX, 2'b00, 2'b00, 1'b0};
      VID_PRE:        if (!dvi) c = '{PERIOD_VID_PRE, MODE_CTRL, MODE_CTRL, MODE_CTRL, 2'b01, 2'b00, 1'b0};
      VID_GUARD:      if (!dvi) c = '{PERIOD_VID_GUARD, MODE_GUARD, MODE_GUARD, MODE_GUARD, 2'b00, 2'b00, 1'b1};
      VIDEO:          c = '{PERIOD_VIDEO, MODE_VIDEO, MODE_VIDEO, MODE_VIDEO, 2'b00, 2'b00, 1'b0};
      default:        ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/hdmi_delay_line.sv
// hdmi_delay_line: fixed-depth shift register with asynchronous clear
module hdmi_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/hdmi_period_ctrl.sv
// hdmi_period_ctrl: TMDS period sequencer and data-island scheduler
module hdmi_period_ctrl
  import hdmi_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int SLOT_LEN     = 32,
  parameter int MAX_PACKETS  = 18,
  parameter int MIN_CTRL     = 4,
  parameter int BLANK_W      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dvi,
  input  logic               de_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [BLANK_W-1:0] blank_left,
  input  logic               aux_request,
  output logic               de_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [2:0]         period,
  output logic [4:0]         aux_slot,
  output logic               packet_end,
  output logic               island_abort,
  output logic [1:0]         ch0_mode,
  output logic [1:0]         ch1_mode,
  output logic [1:0]         ch2_mode,
  output logic [1:0]         ch0_ctrl,
  output logic [1:0]         ch1_ctrl,
  output logic [1:0]         ch2_ctrl,
  output logic               ch2_guard
);
  localparam int LEAD       = PREAMBLE_LEN + GUARD_LEN;
  localparam int ISLAND_MIN = PREAMBLE_LEN + 2 * GUARD_LEN + SLOT_LEN + MIN_CTRL;
  localparam int PACKET_MIN = SLOT_LEN + GUARD_LEN + MIN_CTRL + 1;
  localparam int CW         = $clog2((PREAMBLE_LEN > GUARD_LEN ? PREAMBLE_LEN : GUARD_LEN) + 1);
  localparam int PW         = $clog2(MAX_PACKETS + 1);
  localparam int TW         = $clog2(MIN_CTRL + 1);
  state_t          state, next;
  chan_t           chan;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pkt_cnt, pkt_n;
  logic [TW-1:0]   ctrl_cnt, ctrl_n;
  logic [4:0]      slot_n;
  logic [2:0]      dl;
  logic            de_d, dvi_q, dvi_eff, de_rise, in_aux, abort, last_slot, island_ok, more;
  hdmi_delay_line #(.WIDTH(3), .DEPTH(LEAD)) u_dl (
    .clk(clk),
    .rst_n(rst_n),
    .d({de_in, hsync_in, vsync_in}),
    .q(dl)
  );
  assign de_rise   = de_in && !de_d;
  assign in_aux    = state inside {AUX_PRE, AUX_GL, AUX_DATA, AUX_GT};
  assign abort     = de_rise && in_aux;
  assign dvi_eff   = (state == CTRL) ? dvi : dvi_q;
  assign last_slot = state == AUX_DATA && aux_slot == 5'(SLOT_LEN - 1);
  assign island_ok = !dvi && aux_request && !de_in && ctrl_cnt >= TW'(MIN_CTRL) && blank_left >= BLANK_W'(ISLAND_MIN);
  assign more      = aux_request && pkt_cnt < PW'(MAX_PACKETS - 1) && blank_left >= BLANK_W'(PACKET_MIN);
  // dl[2] is de re-aligned to de_out timing; video entry and exit track it
  always_comb begin
    next = state;
    case (state)
      CTRL:      next = de_rise ? VID_PRE : island_ok ? AUX_PRE : CTRL;
      AUX_PRE:   next = de_rise ? VID_PRE : cnt == CW'(PREAMBLE_LEN - 1) ? AUX_GL : AUX_PRE;
      AUX_GL:    next = de_rise ? VID_PRE : cnt == CW'(GUARD_LEN - 1) ? AUX_DATA : AUX_GL;
      AUX_DATA:  next = de_rise ? VID_PRE : (!last_slot || more) ? AUX_DATA : AUX_GT;
      AUX_GT:    next = de_rise ? VID_PRE : cnt == CW'(GUARD_LEN - 1) ? CTRL : AUX_GT;
      VID_PRE:   next = dl[2] ? VIDEO : cnt == CW'(PREAMBLE_LEN - 1) ? VID_GUARD : VID_PRE;
      VID_GUARD: next = (dl[2] || cnt == CW'(GUARD_LEN - 1)) ? VIDEO : VID_GUARD;
      VIDEO:     next = dl[2] ? VIDEO : de_in ? VID_PRE : CTRL;
      default:   next = CTRL;
    endcase
  end
  always_comb begin
    slot_n = (next == AUX_DATA && state == AUX_DATA && !last_slot) ? aux_slot + 5'd1 : 5'd0;
    pkt_n  = (next == AUX_DATA) ? pkt_cnt + PW'(last_slot) : '0;
    ctrl_n = (next == CTRL && state == CTRL) ? (ctrl_cnt == TW'(MIN_CTRL) ? ctrl_cnt : ctrl_cnt + TW'(1)) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= CTRL;
      cnt          <= '0;
      aux_slot     <= '0;
      pkt_cnt      <= '0;
      ctrl_cnt     <= '0;
      de_d         <= 1'b0;
      dvi_q        <= 1'b0;
      chan         <= chan_of(CTRL, 1'b0);
      packet_end   <= 1'b0;
      island_abort <= 1'b0;
      de_out       <= 1'b0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
    end else begin
      state        <= next;
      cnt          <= (next == state) ? cnt + CW'(1) : '0;
      aux_slot     <= slot_n;
      pkt_cnt      <= pkt_n;
      ctrl_cnt     <= ctrl_n;
      de_d         <= de_in;
      dvi_q        <= dvi_eff;
      chan         <= chan_of(next, dvi_eff);
      packet_end   <= (next == AUX_DATA && slot_n == 5'(SLOT_LEN - 1)) || abort;
      island_abort <= abort;
      de_out       <= dl[2];
      hsync_out    <= dl[1];
      vsync_out    <= dl[0];
    end
  assign period    = chan.period;
  assign ch0_mode  = chan.m0;
  assign ch1_mode  = chan.m1;
  assign ch2_mode  = chan.m2;
  assign ch1_ctrl  = chan.c1;
  assign ch2_ctrl  = chan.c2;
  assign ch2_guard = chan.guard;
  assign ch0_ctrl  = {vsync_out, hsync_out};
  // a de_in rise inside VIDEO means the blank was shorter than LEAD
  no_short_blank: assert property (@(posedge clk) disable iff (!rst_n) !(state == VIDEO && de_rise));
endmodule

// File: tb/tb_hdmi_period_ctrl.sv
// tb_hdmi_period_ctrl: directed self-checking bench for hdmi_period_ctrl
module tb_hdmi_period_ctrl;
  localparam logic [13:0] CTL  = {3'b000, 6'b101010, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] VPRE = {3'b111, 6'b101010, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] VGRD = {3'b110, 6'b000000, 2'b00, 2'b00, 1'b1};
  localparam logic [13:0] VID  = {3'b011, 6'b111111, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] APRE = {3'b101, 6'b101010, 2'b01, 2'b01, 1'b0};
  localparam logic [13:0] AGRD = {3'b100, 6'b010000, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] ADAT = {3'b001, 6'b010101, 2'b00, 2'b00, 1'b0};
  logic        clk = 1'b0, rst_n = 1'b0, dvi = 1'b0, de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, aux_request = 1'b0;
  logic [11:0] blank_left = 12'd0;
  logic        de_out, hsync_out, vsync_out, packet_end, island_abort, ch2_guard;
  logic [2:0]  period;
  logic [4:0]  aux_slot;
  logic [1:0]  ch0_mode, ch1_mode, ch2_mode, ch0_ctrl, ch1_ctrl, ch2_ctrl;
  logic [13:0] obs;
  int          errors = 0, checks = 0;
  bit          countdown = 1'b0;
  always #5 clk = ~clk;
  assign obs = {period, ch0_mode, ch1_mode, ch2_mode, ch1_ctrl, ch2_ctrl, ch2_guard};
  hdmi_period_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dvi(dvi), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blank_left(blank_left), .aux_request(aux_request), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .period(period), .aux_slot(aux_slot), .packet_end(packet_end),
    .island_abort(island_abort), .ch0_mode(ch0_mode), .ch1_mode(ch1_mode), .ch2_mode(ch2_mode),
    .ch0_ctrl(ch0_ctrl), .ch1_ctrl(ch1_ctrl), .ch2_ctrl(ch2_ctrl), .ch2_guard(ch2_guard)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    if (countdown && blank_left != 12'd0) blank_left = blank_left - 12'd1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({obs, aux_slot} !== {CTL, 5'd0}) begin
      errors++;
      $display("FAIL reset_chan got=%h want=%h", {obs, aux_slot}, {CTL, 5'd0});
    end
    checks++;
    if ({de_out, hsync_out, vsync_out, packet_end, island_abort, ch0_ctrl} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000000", {de_out, hsync_out, vsync_out, packet_end, island_abort, ch0_ctrl});
    end
    rst_n = 1'b1;
    ticks(8);
  endtask
  task automatic test_video();
    logic [13:0] e;
    de_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = k <= 8 ? VPRE : k <= 10 ? VGRD : VID;
      checks++;
      if ({obs, de_out} !== {e, k >= 11}) begin
        errors++;
        $display("FAIL video_rise k=%0d got=%h want=%h", k, {obs, de_out}, {e, k >= 11});
      end
    end
    ticks(15);
    de_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = k <= 10 ? VID : CTL;
      checks++;
      if ({obs, de_out} !== {e, k <= 10}) begin
        errors++;
        $display("FAIL video_fall k=%0d got=%h want=%h", k, {obs, de_out}, {e, k <= 10});
      end
    end
  endtask
  task automatic test_sync();
    logic [1:0] e;
    hsync_in = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) {hsync_in, vsync_in} = 2'b01;
      if (k == 2) vsync_in = 1'b0;
      e = k == 11 ? 2'b01 : k == 12 ? 2'b10 : 2'b00;
      checks++;
      if ({ch0_ctrl, vsync_out, hsync_out} !== {e, e}) begin
        errors++;
        $display("FAIL sync k=%0d got=%b want=%b", k, {ch0_ctrl, vsync_out, hsync_out}, {e, e});
      end
    end
  endtask
  task automatic test_island();
    logic [13:0] e;
    logic [4:0]  s;
    logic        d;
    blank_left = 12'd120;
    countdown = 1'b1;
    aux_request = 1'b1;
    for (int k = 1; k <= 112; k++) begin
      tick();
      d = k >= 11 && k <= 106;
      s = d ? 5'((k - 11) % 32) : 5'd0;
      e = k <= 8 ? APRE : k <= 10 ? AGRD : k <= 106 ? ADAT : k <= 108 ? AGRD : CTL;
      checks++;
      if ({obs, aux_slot, packet_end, island_abort} !== {e, s, d && s == 5'd31, 1'b0}) begin
        errors++;
        $display("FAIL island k=%0d got=%h want=%h", k, {obs, aux_slot, packet_end, island_abort}, {e, s, d && s == 5'd31, 1'b0});
      end
    end
    countdown = 1'b0;
    aux_request = 1'b0;
  endtask
  task automatic test_threshold();
    logic [13:0] e;
    int          pulses = 0;
    blank_left = 12'd47;
    aux_request = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (obs !== CTL) begin
        errors++;
        $display("FAIL thresh47 k=%0d got=%h want=%h", k, obs, CTL);
      end
    end
    blank_left = 12'd48;
    countdown = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      pulses += int'(packet_end);
      e = k <= 8 ? APRE : k <= 10 ? AGRD : k <= 42 ? ADAT : k <= 44 ? AGRD : CTL;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL thresh48 k=%0d got=%h want=%h", k, obs, e);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL thresh48_packets got=%0d want=1", pulses);
    end
    countdown = 1'b0;
    aux_request = 1'b0;
  endtask
  task automatic test_dvi();
    dvi = 1'b1;
    aux_request = 1'b1;
    blank_left = 12'd200;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (obs !== CTL) begin
        errors++;
        $display("FAIL dvi_idle k=%0d got=%h want=%h", k, obs, CTL);
      end
    end
    de_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if ({obs, de_out} !== {k <= 10 ? CTL : VID, k >= 11}) begin
        errors++;
        $display("FAIL dvi_rise k=%0d got=%h want=%h", k, {obs, de_out}, {k <= 10 ? CTL : VID, k >= 11});
      end
    end
    ticks(5);
    de_in = 1'b0;
    ticks(12);
    checks++;
    if ({obs, de_out} !== {CTL, 1'b0}) begin
      errors++;
      $display("FAIL dvi_fall got=%h want=%h", {obs, de_out}, {CTL, 1'b0});
    end
    dvi = 1'b0;
    aux_request = 1'b0;
    ticks(3);
  endtask
  task automatic test_abort();
    int n = 0;
    blank_left = 12'd200;
    aux_request = 1'b1;
    while (!(period == 3'b001 && aux_slot == 5'd10) && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL abort_wait timeout period=%b slot=%0d want 001/10", period, aux_slot);
    end
    de_in = 1'b1;
    tick();
    checks++;
    if ({island_abort, packet_end, period, aux_slot} !== {2'b11, 3'b111, 5'd0}) begin
      errors++;
      $display("FAIL abort_pulse got=%b want=%b", {island_abort, packet_end, period, aux_slot}, {2'b11, 3'b111, 5'd0});
    end
    aux_request = 1'b0;
    tick();
    checks++;
    if ({island_abort, packet_end, period} !== {2'b00, 3'b111}) begin
      errors++;
      $display("FAIL abort_after got=%b want=%b", {island_abort, packet_end, period}, {2'b00, 3'b111});
    end
    ticks(9);
    checks++;
    if ({obs, de_out} !== {VID, 1'b1}) begin
      errors++;
      $display("FAIL abort_video got=%h want=%h", {obs, de_out}, {VID, 1'b1});
    end
    ticks(5);
    de_in = 1'b0;
    ticks(12);
    checks++;
    if ({obs, de_out} !== {CTL, 1'b0}) begin
      errors++;
      $display("FAIL abort_end got=%h want=%h", {obs, de_out}, {CTL, 1'b0});
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    blank_left = 12'd200;
    aux_request = 1'b1;
    while (!(period == 3'b001 && aux_slot == 5'd5) && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL rstmid_wait timeout period=%b slot=%0d want 001/5", period, aux_slot);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, aux_slot, de_out, packet_end} !== {CTL, 5'd0, 2'b00}) begin
      errors++;
      $display("FAIL rstmid_async got=%h want=%h", {obs, aux_slot, de_out, packet_end}, {CTL, 5'd0, 2'b00});
    end
    tick();
    checks++;
    if ({obs, aux_slot, de_out} !== {CTL, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_held got=%h want=%h", {obs, aux_slot, de_out}, {CTL, 5'd0, 1'b0});
    end
    rst_n = 1'b1;
    aux_request = 1'b0;
    ticks(3);
    checks++;
    if ({obs, aux_slot} !== {CTL, 5'd0}) begin
      errors++;
      $display("FAIL rstmid_after got=%h want=%h", {obs, aux_slot}, {CTL, 5'd0});
    end
  endtask
  initial begin
    test_reset();
    test_video();
    test_sync();
    test_island();
    test_threshold();
    test_dvi();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
